// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
//   fifo_unit    : default data word type (FIFO_WIDTH_DEFAULT bits wide)
//   fifo_depth   : entry count derived from log2 depth
//   fifo_count_w : bit width needed to hold an occupancy of 0..DEPTH
package fifo_pkg;

  localparam int unsigned FIFO_WIDTH_DEFAULT = 8;

  typedef logic [FIFO_WIDTH_DEFAULT-1:0] fifo_unit;

  function automatic int unsigned fifo_depth(input int unsigned depth_bits);
    return 32'd1 << depth_bits;
  endfunction

  // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
  function automatic int unsigned fifo_count_w(input int unsigned depth_bits);
    return depth_bits + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFO: DEPTH x WIDTH words.
//   clk     : clock
//   reset   : synchronous active-low reset (read register only; storage is not reset)
//   we      : write enable
//   w_addr  : write address
//   w_data  : write data
//   re      : read enable; loads r_data from mem[r_addr] on the edge
//   r_addr  : read address
//   r_data  : registered read data, holds when re is low
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] w_addr,
  input  logic [WIDTH-1:0]      w_data,
  input  logic                  re,
  input  logic [DEPTH_BITS-1:0] r_addr,
  output logic [WIDTH-1:0]      r_data
);

  localparam int unsigned DEPTH = fifo_depth(DEPTH_BITS);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  // The read register is reset so r_data is never X, even though mem is uninitialised.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_data <= '0;
    end else if (re) begin
      r_data <= mem[r_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty flags, flush, and sticky overflow/underflow flags.
//   clk, reset      : clock, synchronous active-low reset
//   push, w_data    : write request and data
//   pop             : read request; r_data/valid appear one cycle later
//   flush           : synchronous clear of contents (error flags kept)
//   clr_err         : clears ovf/udf (a same-cycle set wins)
//   r_data, valid   : registered read data and its new-data strobe
//   ful, ept        : full / empty
//   almost_full     : count >= DEPTH - AF_MARGIN
//   almost_empty    : count <= AE_MARGIN
//   count           : occupancy 0..DEPTH
//   ovf, udf        : sticky rejected-push / rejected-pop flags
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 4,
  parameter int unsigned AF_MARGIN  = 2,
  parameter int unsigned AE_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      w_data,
  input  logic                  pop,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      r_data,
  output logic                  valid,
  output logic                  ful,
  output logic                  ept,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [DEPTH_BITS:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int unsigned DEPTH = fifo_depth(DEPTH_BITS);
  localparam int unsigned CW    = fifo_count_w(DEPTH_BITS);

  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic                  pop_acc;
  logic                  push_acc;
  logic                  ram_we;
  logic                  ram_re;

  // Status flags depend only on the count register, so they move only on edges.
  always_comb begin
    ept          = (count == '0);
    ful          = (count == FULL_LVL);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
  end

  // A pop on empty is rejected even with a same-cycle push (no bypass);
  // a push on full is accepted only when a pop frees the slot.
  always_comb begin
    pop_acc  = pop && !ept;
    push_acc = push && (!ful || pop_acc);
    ram_we   = reset && !flush && push_acc;
    ram_re   = !flush && pop_acc;
  end

  fifo_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (ram_we),
    .w_addr (wr_ptr),
    .w_data (w_data),
    .re     (ram_re),
    .r_addr (rd_ptr),
    .r_data (r_data)
  );

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (pop_acc) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      count <= count + CW'(push_acc) - CW'(pop_acc);
      valid <= pop_acc;
    end
  end

  // Flush discards the push/pop of its cycle, so it raises no error; clr_err still applies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (flush) begin
      if (clr_err) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
    end else begin
      ovf <= (push && !push_acc) || (ovf && !clr_err);
      udf <= (pop && !pop_acc) || (udf && !clr_err);
    end
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Synthesizable, parametrised synchronous FIFO.
- Next generation of the team's single-width, behavioural FIFO model.
- Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty flags, a flush input, and sticky overflow/underflow error flags.
- Sits between a producer and a consumer on one clock domain. It also serves as the DUT that the existing golden model is compared against.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH_BITS, 4, log2 of the entry count; DEPTH = 2**DEPTH_BITS.
- AF_MARGIN, 2, almost_full asserts when count >= DEPTH - AF_MARGIN; legal range 0..DEPTH-1.
- AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN; legal range 0..DEPTH-1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-low reset.
- push, input, 1, write request.
- w_data, input, WIDTH, write data, sampled on an accepted push.
- pop, input, 1, read request.
- flush, input, 1, synchronous clear of contents; error flags are kept.
- clr_err, input, 1, clears ovf and udf.
- r_data, output, WIDTH, registered read data.
- valid, output, 1, r_data holds a newly popped word this cycle.
- ful, output, 1, count == DEPTH.
- ept, output, 1, count == 0.
- almost_full, output, 1, see AF_MARGIN.
- almost_empty, output, 1, see AE_MARGIN.
- count, output, DEPTH_BITS+1, current occupancy, 0..DEPTH.
- ovf, output, 1, sticky: push rejected because the FIFO was full.
- udf, output, 1, sticky: pop rejected because the FIFO was empty.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Pointers and count go to 0, so ept=1, ful=0, almost_empty=1.
  - almost_full=0 (with AF_MARGIN < DEPTH).
  - valid=0, r_data=0, ovf=0, udf=0.
  - Reset overrides every other input, including a reset arriving mid-operation.
- Priority on each clock edge: reset, then flush, then push/pop.
- Flush:
  - Pointers and count go to 0; a push or pop in the same cycle is discarded.
  - The next cycle has valid=0.
  - r_data holds its value; ovf and udf are unaffected.
- Pop acceptance:
  - pop_acc = pop && !ept, evaluated on the pre-edge count.
  - No write-to-read bypass: a pop on an empty FIFO is rejected even if a push is accepted in the same cycle.
- Push acceptance:
  - push_acc = push && (!ful || pop_acc).
  - At full, a simultaneous accepted pop frees the slot, the write is accepted and count is unchanged.
- Count update: count_next = count + push_acc - pop_acc. It never exceeds DEPTH and never underflows.
- Read latency is 1 cycle:
  - On an accepted pop at edge N, r_data gets mem[rd_ptr] and valid=1 after edge N.
  - Otherwise valid=0 after the edge and r_data holds its last value.
- Ordering: strict FIFO order. Word order is preserved through pointer wrap-around.
- Pointers are DEPTH_BITS wide and wrap modulo DEPTH with no special case.
- Status flags (ful, ept, almost_full, almost_empty) are decoded combinationally from the count register. They change only on clock edges, never within a cycle on inputs.
- Error flags:
  - ovf is set when push && !push_acc.
  - udf is set when pop && !pop_acc.
  - clr_err clears both. If a set and a clear occur in the same cycle, the set wins.
  - flush does not change them.
- Memory: storage is not reset; only the pointers define validity.
- X-safety: no output may go X after the first reset, regardless of memory contents.

Decomposition:
- Shared package fifo_pkg holds:
  - the fifo_unit typedef, parametrised on WIDTH via a parameterised class or macro default;
  - the DEPTH = 2**DEPTH_BITS constant function;
  - the count width helper.
  - The golden model and the testbench import it.
- One sub-module, fifo_ram: simple dual-port memory with DEPTH x WIDTH, one write port and one registered read port. The control logic stays in fifo_sync_param.

Test Plan (WIDTH=8, DEPTH_BITS=3, AF_MARGIN=2, AE_MARGIN=1):
1. Reset: hold reset low 2 cycles with push=pop=1 -> ept=1, ful=0, count=0, valid=0, r_data=0x00, ovf=udf=0.
2. Fill: push 0x10..0x17 on consecutive cycles -> almost_empty drops after the 2nd push; almost_full rises after the 6th; ful=1 and count=8 after the 8th. A 9th push is dropped and ovf=1.
3. Drain: pop 8 consecutive cycles -> valid=1 on each following cycle with r_data 0x10..0x17 in order; ept=1 after the last. A 9th pop gives valid=0 and udf=1; clr_err then clears both flags.
4. Full plus simultaneous push/pop with w_data=0xAA -> r_data=0x10, count stays 8, ful stays 1, ovf stays 0. Stream 20 further words with random push/pop -> output order matches input across pointer wrap.
5. Empty plus simultaneous push/pop -> udf=1, valid=0, count=1; the next pop returns the pushed word.
6. Mid-operation control: with count=3, assert flush together with push and pop -> count=0 and valid=0 next cycle, ovf/udf unchanged. Repeat with reset low instead of flush -> the same, plus ovf=udf=0 and r_data=0x00.
